// File: rtl/alu_seq.sv
// alu_seq: registered execute-stage ALU with valid/ready handshake and Z/N/C/V flags.
// Define ALU_SEQ_MUL_EN to add the iterative shift-add multiplier on opcode 1011.
module alu_seq #(
    parameter int WIDTH     = 32,
    parameter int INC_CONST = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v
);

    localparam int MSB = WIDTH - 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DONE = 2'd1;

    logic [1:0]       state;
    logic             accept;
    logic             is_mul;
    logic [WIDTH-1:0] r;
    logic             rc;
    logic             rv;
    logic [WIDTH:0]   ext;

`ifdef ALU_SEQ_MUL_EN
    localparam logic [1:0] BUSY = 2'd2;
    localparam int         CW   = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    assign is_mul = (op == 4'b1011);
`else
    // Opcode 1011 decodes as undefined; there is no multi-cycle path.
    assign is_mul = 1'b0;
`endif

    assign out_valid = (state == DONE);
    assign in_ready  = (state == IDLE) | (out_valid & out_ready);
    assign accept    = in_valid & in_ready;

    // Single-cycle result and carry/overflow for the presented opcode.
    always_comb begin
        r   = '0;
        rc  = 1'b0;
        rv  = 1'b0;
        ext = '0;
        case (op)
            4'b0000: begin
                ext = {1'b0, a} + {1'b0, b};
                r   = ext[MSB:0];
                rc  = ext[WIDTH];
                rv  = ~(a[MSB] ^ b[MSB]) & (a[MSB] ^ r[MSB]);
            end
            4'b0001: begin
                ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
                r   = ext[MSB:0];
                rc  = ext[WIDTH];
                rv  = ~(a[MSB] ^ b[MSB]) & (a[MSB] ^ r[MSB]);
            end
            4'b0010: begin
                r  = a - b;
                rc = (a < b);
                rv = (a[MSB] ^ b[MSB]) & (a[MSB] ^ r[MSB]);
            end
            4'b0011: begin
                // a - b - ci in WIDTH+1 bits: the top bit is the borrow
                ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, ci};
                r   = ext[MSB:0];
                rc  = ext[WIDTH];
                rv  = (a[MSB] ^ b[MSB]) & (a[MSB] ^ r[MSB]);
            end
            4'b0100: begin
                r  = b - a;
                rc = (a > b);
            end
            4'b0101: r = a | b;
            4'b0110: r = a ^ b;
            4'b0111: r = a & b;
            4'b1000: r = a;
            4'b1001: r = a + WIDTH'(INC_CONST);
            4'b1010: r = b;
            default: r = '0;
        endcase
    end

    // Handshake state, result/flag registers and the multiply iteration.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            out   <= '0;
            z     <= 1'b0;
            n     <= 1'b0;
            c     <= 1'b0;
            v     <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
`endif
        end else if (accept && !is_mul) begin
            out   <= r;
            z     <= (r == '0);
            n     <= r[MSB];
            c     <= rc;
            v     <= rv;
            state <= DONE;
`ifdef ALU_SEQ_MUL_EN
        end else if (accept) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
            state  <= BUSY;
        end else if (state == BUSY) begin
            if (cnt == CW'(WIDTH)) begin
                out   <= acc[MSB:0];
                z     <= (acc[MSB:0] == '0);
                n     <= acc[MSB];
                c     <= |acc[2*WIDTH-1:WIDTH];
                v     <= |acc[2*WIDTH-1:WIDTH];
                state <= DONE;
            end else begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
            end
`endif
        end else if (out_valid && out_ready) begin
            state <= IDLE;
        end
    end

endmodule
